latch_fifo_rd: RTL

Read-side controller for the latch-array FIFO used in the adapter datapath; the companion write controller fills a DEPTH-entry array of `latch_rn` storage cells and advances a write pointer. This block tracks the write pointer with a settle delay so latches are never read while transparent, selects the oldest entry, and presents it through a registered valid/ready output stage. It returns its read pointer to the writer for full detection.

---
 rtl/latch_fifo_rd.sv | 100 ++++++++++
 1 files changed

// File: rtl/latch_fifo_rd.sv
// Read-side controller for the latch-array FIFO: settled write pointer,
// oldest-entry select, registered valid/ready output. Option: LATCH_FIFO_RD_SYNC2_EN.
module latch_fifo_rd #(
  parameter int WIDTH      = 40,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                          clk,
  input  logic                          rn,
  input  logic [DEPTH_LOG2:0]           wr_ptr,
  input  logic [(2**DEPTH_LOG2)*WIDTH-1:0] mem_data,
  input  logic                          dout_ready,
  output logic                          dout_valid,
  output logic [WIDTH-1:0]              dout,
  output logic [DEPTH_LOG2:0]           rd_ptr,
  output logic                          empty,
  output logic [DEPTH_LOG2+1:0]         level,
  output logic                          ptr_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int LW    = DEPTH_LOG2 + 2;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [WIDTH-1:0]      dout_q, dout_d;
  logic                  ptr_err_q, ptr_err_d;
  logic [PW-1:0]         avail;
  logic                  over;
  logic                  load;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [WIDTH-1:0]      rd_word;

`ifdef LATCH_FIFO_RD_SYNC2_EN
  logic [PW-1:0] wr_ptr_q1;

  // Two-stage settle for latches written on the falling edge
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      wr_ptr_q1 <= '0;
      wr_ptr_q  <= '0;
    end else begin
      wr_ptr_q1 <= wr_ptr;
      wr_ptr_q  <= wr_ptr_q1;
    end
  end
`else
  // Single-stage settle: entries are only read once stable
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) wr_ptr_q <= '0;
    else     wr_ptr_q <= wr_ptr;
  end
`endif

  // Availability, load decision and next-state of the output stage
  always_comb begin
    avail        = wr_ptr_q - rd_ptr_q;
    over         = avail > DEPTH_C;
    load         = !over && (avail != '0) &&
                   (!dout_valid_q || dout_ready);
    rd_idx       = rd_ptr_q[DEPTH_LOG2-1:0];
    rd_word      = mem_data[int'(rd_idx)*WIDTH +: WIDTH];
    rd_ptr_d     = rd_ptr_q;
    dout_valid_d = dout_valid_q;
    dout_d       = dout_q;
    ptr_err_d    = ptr_err_q | over;
    if (load) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      dout_valid_d = 1'b1;
      dout_d       = rd_word;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // Output stage and read pointer registers
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      rd_ptr_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      ptr_err_q    <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      ptr_err_q    <= ptr_err_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign rd_ptr     = rd_ptr_q;
  assign ptr_err    = ptr_err_q;
  assign empty      = (avail == '0) && !dout_valid_q;
  assign level      = LW'(avail) + LW'(dout_valid_q);

endmodule
